// File: rtl/mar_seq_if.sv
// Bus bundle between the datapath/memory side and the mar_seq address sequencer.
// The master modport drives address, control and MOC; the slave modport is the sequencer.
interface mar_seq_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] In_MAR;
    logic              MAR_Ld;
    logic              MAR_Inc;
    logic [1:0]        Size;
    logic              Mem_Start;
    logic              MOC;
    logic [ADDR_W-1:0] Out_MAR;
    logic              MFA;
    logic              Busy;
    logic              Done;
    logic              Align_Err;
    logic              Timeout_Err;

    modport master (
        output In_MAR, MAR_Ld, MAR_Inc, Size, Mem_Start, MOC,
        input  Out_MAR, MFA, Busy, Done, Align_Err, Timeout_Err
    );

    modport slave (
        input  In_MAR, MAR_Ld, MAR_Inc, Size, Mem_Start, MOC,
        output Out_MAR, MFA, Busy, Done, Align_Err, Timeout_Err
    );
endinterface

// File: rtl/mar_seq.sv
// Memory address register with load/increment and a one-access MFA/MOC request sequencer.
// Optional MAR_SEQ_AUTOINC_EN: advance Out_MAR by the latched access size on successful completion.
module mar_seq #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input logic      Clk,
    input logic      Reset,
    mar_seq_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_q;
    logic [ADDR_W-1:0] out_mar_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mfa_q;
    logic              busy_q;
    logic              done_q;
    logic              align_err_q;
    logic              timeout_err_q;
`ifdef MAR_SEQ_AUTOINC_EN
    logic [1:0]        size_q;
`endif

    logic [ADDR_W-1:0] target_d;
    logic [ADDR_W-1:0] inc_d;
    logic              start_ok_d;
    logic              start_bad_d;
    logic              timeout_hit_d;

    function automatic logic [ADDR_W-1:0] step_of(input logic [1:0] sz);
        return ADDR_W'(1) << sz;
    endfunction

    function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            default: return 1'b1;
        endcase
    endfunction

    // The access address is the value being loaded this cycle, otherwise the pre-increment register.
    always_comb begin
        target_d      = bus.MAR_Ld ? bus.In_MAR : out_mar_q;
        inc_d         = out_mar_q + step_of(bus.Size);
        start_bad_d   = bus.Mem_Start && misaligned(target_d, bus.Size);
        start_ok_d    = bus.Mem_Start && !misaligned(target_d, bus.Size);
        timeout_hit_d = TO_EN && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            out_mar_q     <= '0;
            cnt_q         <= '0;
            mfa_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef MAR_SEQ_AUTOINC_EN
            size_q        <= 2'b00;
`endif
        end else begin
            done_q        <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.MAR_Ld) begin
                        out_mar_q <= bus.In_MAR;
                    end else if (bus.MAR_Inc) begin
                        out_mar_q <= inc_d;
                    end
                    if (start_bad_d) begin
                        done_q      <= 1'b1;
                        align_err_q <= 1'b1;
                    end else if (start_ok_d) begin
                        state_q <= REQ;
                        mfa_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
`ifdef MAR_SEQ_AUTOINC_EN
                        size_q  <= bus.Size;
`endif
                    end
                end
                REQ: begin
                    // MOC is checked first so a completion in the last allowed cycle is not an error.
                    if (bus.MOC) begin
                        state_q <= IDLE;
                        mfa_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef MAR_SEQ_AUTOINC_EN
                        out_mar_q <= out_mar_q + step_of(size_q);
`endif
                    end else if (timeout_hit_d) begin
                        state_q       <= IDLE;
                        mfa_q         <= 1'b0;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mfa_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Out_MAR     = out_mar_q;
    assign bus.MFA         = mfa_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Align_Err   = align_err_q;
    assign bus.Timeout_Err = timeout_err_q;
endmodule

// File: tb/tb_mar_seq.sv
// Bench for mar_seq: directed vector table, hand-written request sequences and a random run
// checked every cycle against a transaction-level reference model.
module tb_mar_seq;
    localparam int ADDR_W = 32;
    localparam int TO     = 15;
`ifdef MAR_SEQ_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mar_seq_if #(.ADDR_W(ADDR_W)) bus ();
    mar_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: address value, whether a request is outstanding, how many
    // cycles MFA has been high so far, the size latched at start, and the pulse outputs.
    logic [31:0] m_addr;
    bit          m_req;
    int          m_high;
    logic [1:0]  m_size;
    bit          m_done, m_aerr, m_terr;

    typedef struct {
        bit          ld, inc, start, moc;
        logic [1:0]  size;
        logic [31:0] in;
        logic [31:0] e_addr;
        bit          e_mfa, e_done, e_aerr;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_model(input string tag);
        chk(tag, {27'd0, bus.Out_MAR, bus.MFA, bus.Busy, bus.Done, bus.Align_Err, bus.Timeout_Err},
                 {27'd0, m_addr, m_req, m_req, m_done, m_aerr, m_terr});
    endtask

    task automatic drive(input bit ld, input bit inc, input bit start, input bit moc,
                         input logic [1:0] size, input logic [31:0] in);
        bus.MAR_Ld = ld; bus.MAR_Inc = inc; bus.Mem_Start = start; bus.MOC = moc;
        bus.Size = size; bus.In_MAR = in;
    endtask

    task automatic tick();
        logic [31:0] na, a;
        bit nreq, nd, nae, nte;
        int nh;
        logic [1:0] ns;
        na = m_addr; nreq = m_req; nh = m_high; ns = m_size; nd = 0; nae = 0; nte = 0;
        if (rst) begin
            na = 0; nreq = 0; nh = 0;
        end else if (!m_req) begin
            a = bus.MAR_Ld ? bus.In_MAR : m_addr;
            if (bus.MAR_Ld) na = bus.In_MAR;
            else if (bus.MAR_Inc) na = m_addr + (32'd1 << bus.Size);
            if (bus.Mem_Start) begin
                if (bus.Size == 2'd3 || (a % (32'd1 << bus.Size)) != 0) begin
                    nd = 1; nae = 1;
                end else begin
                    nreq = 1; nh = 1; ns = bus.Size;
                end
            end
        end else begin
            if (bus.MOC) begin
                nreq = 0; nd = 1;
                if (AI) na = m_addr + (32'd1 << m_size);
            end else if (TO != 0 && m_high == TO) begin
                nreq = 0; nd = 1; nte = 1;
            end else begin
                nh = m_high + 1;
            end
        end
        @(posedge clk);
        #1;
        m_addr = na; m_req = nreq; m_high = nh; m_size = ns;
        m_done = nd; m_aerr = nae; m_terr = nte;
    endtask

    function automatic vec_t mk(bit ld, bit inc, bit start, bit moc, logic [1:0] size,
                                logic [31:0] in, logic [31:0] e_addr, bit e_mfa, bit e_done, bit e_aerr);
        vec_t v;
        v.ld = ld; v.inc = inc; v.start = start; v.moc = moc; v.size = size; v.in = in;
        v.e_addr = e_addr; v.e_mfa = e_mfa; v.e_done = e_done; v.e_aerr = e_aerr;
        return v;
    endfunction

    // Assumes the start edge already happened; MOC is raised during MFA-high cycle moc_at (0 = never).
    task automatic run_req(input string tag, input int moc_at, output int hi, output bit seen,
                           output bit te, output bit ae, output logic [31:0] addr_done);
        hi = 0; seen = 0; te = 0; ae = 0; addr_done = '0;
        for (int i = 0; i < 60; i++) begin
            if (bus.Done) begin
                seen = 1; te = bus.Timeout_Err; ae = bus.Align_Err; addr_done = bus.Out_MAR;
                break;
            end
            if (bus.MFA) hi++;
            bus.MOC = (moc_at != 0) && bus.MFA && (hi == moc_at);
            tick();
            chk_model(tag);
        end
        bus.MOC = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        tick();
        chk({tag, "_done_pulse_end"}, 64'(bus.Done), 64'd0);
        chk_model(tag);
    endtask

    initial begin
        logic [31:0] a15, a16;
        int hi;
        bit seen, te, ae;
        logic [31:0] adone;

        rst = 1'b1;
        drive(0, 0, 0, 0, 2'd0, 32'd0);
        m_addr = 0; m_req = 0; m_high = 0; m_size = 0; m_done = 0; m_aerr = 0; m_terr = 0;
        tick();
        tick();
        chk("reset_outputs", {27'd0, bus.Out_MAR, bus.MFA, bus.Busy, bus.Done, bus.Align_Err, bus.Timeout_Err}, 64'd0);
        rst = 1'b0;

        a15 = AI ? 32'h204 : 32'h200;
        a16 = a15 + 32'd2;
        //          ld inc st moc size in            e_addr                         mfa done aerr
        vt.push_back(mk(1, 0, 0, 0, 2'd0, 32'h0000_1000, 32'h0000_1000,               0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'h0,         32'h0000_1004,               0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'h0,         32'h0000_1008,               0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd2, 32'h0,         32'h0000_100C,               0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 2'd2, 32'h20,        32'h20,                      0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE,               0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 2'd1, 32'h0,         32'h0,                       0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 2'd0, 32'h102,       32'h102,                     0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd2, 32'h0,         32'h102,                     0, 1, 1));
        vt.push_back(mk(1, 0, 0, 0, 2'd0, 32'h100,       32'h100,                     0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd3, 32'h0,         32'h100,                     0, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 2'd0, 32'h0,         32'h100,                     0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2'd0, 32'h0,         32'h100,                     1, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 2'd0, 32'h0,         AI ? 32'h101 : 32'h100,      0, 1, 0));
        vt.push_back(mk(1, 0, 1, 0, 2'd2, 32'h200,       32'h200,                     1, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 2'd0, 32'h0,         a15,                         0, 1, 0));
        vt.push_back(mk(0, 1, 1, 0, 2'd1, 32'h0,         a16,                         1, 0, 0));
        vt.push_back(mk(1, 1, 1, 0, 2'd2, 32'hABC,       a16,                         1, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 2'd0, 32'h0,         AI ? a16 + 32'd2 : a16,      0, 1, 0));
        vt.push_back(mk(1, 1, 1, 0, 2'd1, 32'h301,       32'h301,                     0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 2'd0, 32'h0,         32'h301,                     0, 0, 0));

        foreach (vt[i]) begin
            drive(vt[i].ld, vt[i].inc, vt[i].start, vt[i].moc, vt[i].size, vt[i].in);
            tick();
            chk($sformatf("vec%0d_addr", i), 64'(bus.Out_MAR), 64'(vt[i].e_addr));
            chk($sformatf("vec%0d_flags", i), 64'({bus.MFA, bus.Busy, bus.Done, bus.Align_Err, bus.Timeout_Err}),
                64'({vt[i].e_mfa, vt[i].e_mfa, vt[i].e_done, vt[i].e_aerr, 1'b0}));
            chk_model($sformatf("vec%0d_model", i));
        end

        // MOC in the third MFA cycle: MFA high exactly 3 cycles.
        drive(1, 0, 0, 0, 2'd2, 32'h100); tick();
        drive(0, 0, 1, 0, 2'd2, 32'h0);   tick();
        drive(0, 0, 0, 0, 2'd2, 32'h0);
        run_req("moc3", 3, hi, seen, te, ae, adone);
        chk("moc3_mfa_cycles", 64'(hi), 64'd3);
        chk("moc3_errs", 64'({te, ae}), 64'd0);
        chk("moc3_addr", 64'(adone), AI ? 64'h104 : 64'h100);

        // MOC never arrives: timeout after TO cycles of MFA.
        drive(1, 0, 1, 0, 2'd2, 32'h40); tick();
        drive(0, 0, 0, 0, 2'd2, 32'h0);
        run_req("tmo", 0, hi, seen, te, ae, adone);
        chk("tmo_mfa_cycles", 64'(hi), 64'(TO));
        chk("tmo_err", 64'({te, ae}), 64'b10);
        chk("tmo_addr", 64'(adone), 64'h40);

        // MOC in the last allowed cycle wins over the timeout.
        drive(0, 0, 1, 0, 2'd2, 32'h0); tick();
        drive(0, 0, 0, 0, 2'd2, 32'h0);
        run_req("moc_last", TO, hi, seen, te, ae, adone);
        chk("moc_last_mfa_cycles", 64'(hi), 64'(TO));
        chk("moc_last_err", 64'({te, ae}), 64'd0);

        // Reset during the second REQ cycle.
        drive(1, 0, 1, 0, 2'd2, 32'h80); tick();
        drive(0, 0, 0, 0, 2'd2, 32'h0);  tick();
        chk("rst_mid_pre", 64'(bus.MFA), 64'd1);
        rst = 1'b1; tick();
        chk("rst_mid_outputs", {27'd0, bus.Out_MAR, bus.MFA, bus.Busy, bus.Done, bus.Align_Err, bus.Timeout_Err}, 64'd0);
        rst = 1'b0; bus.MOC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mid_no_done", 64'(bus.Done), 64'd0);
            chk_model("rst_mid_model");
        end
        bus.MOC = 1'b0;

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rin;
            rin = $urandom;
            if ($urandom_range(0, 1) == 0) rin = rin & 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), rin);
            tick();
            chk_model("rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mar_seq.md
Name: mar_seq

Overview:
- Parametrised successor to the processor's memory address register (MAR).
- Holds the memory address and supports load and size-stepped increment.
- Sequences one memory access per request using the MFA/MOC handshake, with an alignment check and a timeout.
- Sits between the datapath (address source, control unit) and the memory interface.

Parameters:
ADDR_W, 32, width of address register and In_MAR/Out_MAR
TIMEOUT, 15, max cycles MFA may stay high without MOC; 0 disables timeout
CNT_W, $clog2(TIMEOUT+1) (min 1), width of internal wait counter

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
In_MAR  input  ADDR_W  address to load
MAR_Ld  input  1  load In_MAR into Out_MAR
MAR_Inc  input  1  add access step to Out_MAR
Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal
Mem_Start  input  1  request one memory access at current/loaded address
MOC  input  1  memory operation complete, from memory
Out_MAR  output  ADDR_W  registered address to memory
MFA  output  1  memory function active (request to memory)
Busy  output  1  high while state is REQ
Done  output  1  one-cycle pulse ending every request (success or error)
Align_Err  output  1  valid with Done: request rejected, misaligned or illegal Size
Timeout_Err  output  1  valid with Done: request aborted by timeout

Behaviour:
- Reset (sampled at posedge Clk with Reset=1):
  - Out_MAR=0, MFA=0, Busy=0, Done=0, Align_Err=0, Timeout_Err=0.
  - Counter=0, state=IDLE.
  - Reset has priority over every other input, including mid-request; MFA drops at that edge.
- Step = 1 << Size (1/2/4).
- Increment arithmetic: Out_MAR + step, modulo 2^ADDR_W (wraps; no carry out).
- Done, Align_Err and Timeout_Err are registered. Each is high for exactly one cycle, then 0.
- State IDLE:
  - MAR_Ld=1: Out_MAR <= In_MAR. MAR_Ld has priority over MAR_Inc; simultaneous assertion loads only.
  - MAR_Inc=1 (MAR_Ld=0): Out_MAR <= Out_MAR + step.
  - Mem_Start=1: target address A = In_MAR if MAR_Ld=1 this cycle, else Out_MAR. When MAR_Inc is also asserted, the increment applies to Out_MAR; A is the pre-increment value.
  - Misaligned means: Size=01 and A[0]!=0; Size=10 and A[1:0]!=0; or Size=11.
  - If misaligned: stay IDLE, MFA stays 0; next cycle Done=1 and Align_Err=1.
  - Else: go to REQ; next cycle MFA=1, Busy=1, counter=0.
  - Mem_Start is accepted in the cycle Done is high (back-to-back requests allowed).
- State REQ:
  - Out_MAR is frozen; MAR_Ld, MAR_Inc and Mem_Start are ignored.
  - MOC sampled 1: MFA<=0, Busy<=0, Done<=1, state<=IDLE.
  - Otherwise counter increments.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with MOC=0: MFA<=0, Busy<=0, Done<=1, Timeout_Err<=1, state<=IDLE.
  - Result: MFA is high for at most TIMEOUT cycles.
  - MOC and timeout in the same cycle: MOC wins, no error.
  - TIMEOUT=0: waits for MOC indefinitely.
- Latency:
  - Mem_Start to MFA high: 1 cycle.
  - MOC to Done: 1 cycle.
  - Minimum request: MFA high for 1 cycle when MOC=1 in the first REQ cycle.
- MOC while IDLE: ignored.
- Size is sampled only at Mem_Start; the size latched at that cycle is the one used for any post-increment (see optional feature).

Optional Feature:
- Macro: MAR_SEQ_AUTOINC_EN.
- Defined: on successful completion (MOC accepted, no error), Out_MAR <= Out_MAR + step(latched Size) at the same edge Done is set, with wrap. Error completions leave Out_MAR unchanged.
- Undefined: Out_MAR is never modified by request completion; only MAR_Ld, MAR_Inc and Reset change it.

Test Plan:
- Reset then MAR_Ld with In_MAR=0x0000_1000 -> Out_MAR=0x0000_1000 after 1 edge. MAR_Inc with Size=10 x3 -> 0x0000_100C. MAR_Ld+MAR_Inc together with In_MAR=0x20 -> 0x20.
- Out_MAR=0xFFFF_FFFE, Size=01, MAR_Inc -> Out_MAR=0x0000_0000 (wrap).
- Out_MAR=0x100, Size=10, Mem_Start, MOC high 3 cycles after MFA rises -> MFA high exactly 3 cycles, Done pulses once, errors 0.
  - With MAR_SEQ_AUTOINC_EN: Out_MAR=0x104 at the Done cycle.
  - Without it: Out_MAR stays 0x100.
- Out_MAR=0x102, Size=10, Mem_Start -> MFA never rises; next cycle Done=1, Align_Err=1, Out_MAR=0x102. Size=11 at 0x100 -> same result.
- TIMEOUT=15, MOC held 0 -> MFA high 15 cycles, then Done=1, Timeout_Err=1. Second run with MOC=1 in cycle 15 -> Done with Timeout_Err=0.
- Reset asserted during the 2nd REQ cycle -> all outputs 0 after that edge. MOC=1 afterwards -> no Done.
